rf_wport_arbiter: RTL and testbench
===================================

# rf_wport_arbiter

Shares the single register-file write port between the in-order writeback stage (port A) and a long-latency result source such as the divider or CSR unit (port B). Port B results are parked in a one-entry holding buffer and drained into idle write-port cycles, on a write-after-write conflict, or after a bounded starvation period. The block registers the winning write, drives the register-file write bus, the trace debug interface and the forwarding/pending information used by decode.

## Interface
Parameters:
- STARVE_MAX, 4: cycles a buffered B entry may wait before A is forcibly stalled; must be at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low; state is cleared at a posedge where reset==0.
- a_valid  in  1  WB-stage instruction retiring this cycle.
- a_ready  out  1  A accepted this cycle; feeds ws_ready_go.
- a_we  in  1  A writes a GPR.
- a_dest  in  5  A destination register.
- a_wdata  in  32  A result.
- a_pc  in  32  A PC.
- b_valid  in  1  B result available.
- b_ready  out  1  B accepted.
- b_dest  in  5  B destination register.
- b_wdata  in  32  B result.
- b_pc  in  32  B PC.
- rf_bus  out  `RF_WPORT_BUS_WD` (38)  {we[37], waddr[36:32], wdata[31:0]}.
- pend_valid  out  1  buffer holds an unwritten B result.
- pend_dest  out  5  destination of the buffered B result.
- debug_wb_pc  out  32  PC of the registered write.
- debug_wb_rf_we  out  4  {4{rf we}}.
- debug_wb_rf_wnum  out  5  registered waddr.
- debug_wb_rf_wdata  out  32  registered wdata.

## Operation
- Buffer FSM states: EMPTY and FULL. In EMPTY, b_valid moves the FSM to FULL and latches dest, wdata and pc. In FULL, grant_b moves the FSM to EMPTY.
- b_ready = (state==EMPTY) && reset. There is no accept-while-draining.
- waw = a_valid && a_we && a_dest!=0 && a_dest==buf_dest.
- starve = (cnt==STARVE_MAX).
- grant_b = FULL && (!a_valid || waw || starve).
- a_ready = reset && !grant_b. When a_valid is high, A occupies the port even if a_we==0, so every retirement produces exactly one trace record.
- Output register load:
  - If grant_b: the buffered entry, with we = (buf_dest!=0).
  - Else if a_valid: we = a_we && a_dest!=0, plus A's dest, wdata and pc.
  - Otherwise: we = 0, and waddr, wdata and pc hold their previous values.
- Writes to r0 are consumed but never asserted on rf_bus.
- Starvation counter cnt (width $clog2(STARVE_MAX+1)):
  - Cleared on grant_b or when EMPTY.
  - Incremented while FULL && !grant_b.
  - Saturates at STARVE_MAX.
- pend_valid = FULL and pend_dest = buf_dest. Decode uses these to stall RAW hazards on buffered results.

## Timing
- The grant decision is combinational in cycle N. rf_bus and debug outputs take the winner from cycle N+1, and the RF commits at the end of N+1.
- B acceptance to earliest write: accept at N, FULL at N+1, grant at N+1, rf_bus at N+2.
- Sustained B throughput is one result per 2 cycles.
- a_ready depends combinationally on a_valid, a_we and a_dest, plus registered state. a_valid must not depend on a_ready.
- Reset values: FULL=0, cnt=0, rf we=0, waddr=0, wdata=0, debug_wb_pc=0, pend_valid=0. a_ready and b_ready are 0 while reset==0.
- Reset mid-operation drops any buffered B entry.
- Simultaneous b_valid and A retire while EMPTY: B is buffered and A writes. Both succeed.

## Configuration
- RF_ARB_STARVE_GUARD_EN defined: starvation counter is present; A is stalled for one cycle when cnt==STARVE_MAX.
- Undefined: counter is removed and starve=0. B drains only in A-idle cycles or on waw, so unbounded wait is possible.

## Structure
- `RF_WPORT_BUS_WD` and the rf_bus field offsets belong in the shared header myCPU.h. The WB stage and regfile use the same definitions.
- The one-entry buffer with its EMPTY/FULL state is a natural sub-module, wport_hold_buf. It exposes a valid/ready input, a full flag, a drain strobe and the stored fields.

## Test plan
- Reset: hold reset=0 for 3 cycles with b_valid=1 -> b_ready=0, a_ready=0, rf we=0, pend_valid=0.
- Idle drain: b_valid with dest=5, data=0x1234, a_valid=0 -> next cycle pend_valid=1 and pend_dest=5; the cycle after, rf_bus={1,5,0x1234}.
- WAW: B dest=7 buffered, then A writes r7 with 0xAAAA -> a_ready=0 and B's value is written first; A writes 0xAAAA one cycle later.
- Starvation (macro defined, STARVE_MAX=4): B buffered while A writes r3 every cycle -> exactly 4 A writes, then one a_ready=0 cycle grants B. With the macro undefined, B stays pending.
- r0 suppression: A with a_we=1, a_dest=0 -> a_ready=1, rf we=0, debug_wb_pc=a_pc.
- Reset mid-operation: B buffered, then reset=0 for 1 cycle -> pend_valid=0 and the buffered value is never written.

Source files
------------

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Bus width macro and field offsets are shared with the WB stage and regfile.
`ifndef RF_WPORT_BUS_WD
`define RF_WPORT_BUS_WD 38
`endif

package rf_wport_arbiter_pkg;

    localparam int RF_BUS_WE      = 37;
    localparam int RF_BUS_ADDR_HI = 36;
    localparam int RF_BUS_ADDR_LO = 32;
    localparam int RF_BUS_DATA_HI = 31;
    localparam int RF_BUS_DATA_LO = 0;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Write-port request interface: in-order WB results (A) and
// long-latency results (B), each with a valid/ready handshake.
interface rf_wport_arbiter_if;

    logic        a_valid;
    logic        a_ready;
    logic        a_we;
    logic [4:0]  a_dest;
    logic [31:0] a_wdata;
    logic [31:0] a_pc;

    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_dest;
    logic [31:0] b_wdata;
    logic [31:0] b_pc;

    modport master (
        output a_valid, a_we, a_dest, a_wdata, a_pc,
        output b_valid, b_dest, b_wdata, b_pc,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_we, a_dest, a_wdata, a_pc,
        input  b_valid, b_dest, b_wdata, b_pc,
        output a_ready, b_ready
    );

endinterface

// File: rtl/rf_wport_arbiter_wport_hold_buf.sv
// One-entry holding buffer for long-latency results.
// Accepts only when empty; drain strobe empties it.
module wport_hold_buf
    import rf_wport_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_dest,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_pc,
    input  logic        drain,
    output logic        full,
    output logic [4:0]  buf_dest,
    output logic [31:0] buf_wdata,
    output logic [31:0] buf_pc
);

    buf_state_t state_q;
    buf_state_t state_d;
    logic       load;

    // State register; reset drops any parked entry.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= BUF_EMPTY;
        else        state_q <= state_d;
    end

    // Next state, accept and load strobe.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        load     = 1'b0;
        unique case (state_q)
            BUF_EMPTY: begin
                in_ready = reset;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (drain) state_d = BUF_EMPTY;
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    // Capture the accepted result fields.
    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_dest  <= '0;
            buf_wdata <= '0;
            buf_pc    <= '0;
        end else if (load) begin
            buf_dest  <= in_dest;
            buf_wdata <= in_wdata;
            buf_pc    <= in_pc;
        end
    end

    assign full = (state_q == BUF_FULL);

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter between WB (A) and a buffered B source.
// Define RF_ARB_STARVE_GUARD_EN to bound how long a buffered B waits.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    rf_wport_arbiter_if.slave           bus,
    output logic [`RF_WPORT_BUS_WD-1:0] rf_bus,
    output logic                        pend_valid,
    output logic [4:0]                  pend_dest,
    output logic [31:0]                 debug_wb_pc,
    output logic [3:0]                  debug_wb_rf_we,
    output logic [4:0]                  debug_wb_rf_wnum,
    output logic [31:0]                 debug_wb_rf_wdata
);

    logic        full;
    logic [4:0]  buf_dest;
    logic [31:0] buf_wdata;
    logic [31:0] buf_pc;
    logic        waw;
    logic        starve;
    logic        grant_b;

    logic        we_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;

    wport_hold_buf u_hold_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.b_valid),
        .in_ready  (bus.b_ready),
        .in_dest   (bus.b_dest),
        .in_wdata  (bus.b_wdata),
        .in_pc     (bus.b_pc),
        .drain     (grant_b),
        .full      (full),
        .buf_dest  (buf_dest),
        .buf_wdata (buf_wdata),
        .buf_pc    (buf_pc)
    );

    assign waw = bus.a_valid && bus.a_we && (bus.a_dest != 5'd0)
              && (bus.a_dest == buf_dest);

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt;

    // Count cycles a parked B entry loses to A; saturates.
    always_ff @(posedge clk) begin
        if (!reset || !full || grant_b) cnt <= '0;
        else if (cnt != CNT_MAX)        cnt <= cnt + CW'(1);
    end

    assign starve = (cnt == CNT_MAX);
`else
    assign starve = 1'b0;
`endif

    assign grant_b     = full && (!bus.a_valid || waw || starve);
    assign bus.a_ready = reset && !grant_b;

    // Register the winning write; idle cycles keep the last fields.
    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
        end else if (grant_b) begin
            we_q    <= (buf_dest != 5'd0);
            waddr_q <= buf_dest;
            wdata_q <= buf_wdata;
            pc_q    <= buf_pc;
        end else if (bus.a_valid) begin
            we_q    <= bus.a_we && (bus.a_dest != 5'd0);
            waddr_q <= bus.a_dest;
            wdata_q <= bus.a_wdata;
            pc_q    <= bus.a_pc;
        end else begin
            we_q    <= 1'b0;
        end
    end

    assign rf_bus            = {we_q, waddr_q, wdata_q};
    assign pend_valid        = full;
    assign pend_dest         = buf_dest;
    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_we    = {4{we_q}};
    assign debug_wb_rf_wnum  = waddr_q;
    assign debug_wb_rf_wdata = wdata_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed scoreboard bench for rf_wport_arbiter.
// Checks handshakes, pending info and the registered write each cycle.
module tb_rf_wport_arbiter;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } rec_t;

    logic        clk;
    logic        reset;
    logic [37:0] rf_bus;
    logic        pend_valid;
    logic [4:0]  pend_dest;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int checks;
    int failures;

    rec_t        sb[$];
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    logic [31:0] last_pc;

    rf_wport_arbiter_if bus();

    rf_wport_arbiter #(.STARVE_MAX(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .rf_bus            (rf_bus),
        .pend_valid        (pend_valid),
        .pend_dest         (pend_dest),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rec_t w(input logic we, input logic [4:0] a,
                               input logic [31:0] d, input logic [31:0] p);
        rec_t r;
        last_addr = a;
        last_data = d;
        last_pc   = p;
        r = '{we: we, addr: a, data: d, pc: p};
        return r;
    endfunction

    function automatic rec_t idle();
        rec_t r;
        r = '{we: 1'b0, addr: last_addr, data: last_data, pc: last_pc};
        return r;
    endfunction

    function automatic rec_t rst();
        return w(1'b0, 5'd0, 32'd0, 32'd0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic ar, input logic br, input logic pv,
                        input logic [4:0] pd, input rec_t rec);
        rec_t e;
        @(negedge clk);
        chk("a_ready", 64'(bus.a_ready), 64'(ar));
        chk("b_ready", 64'(bus.b_ready), 64'(br));
        chk("pend_valid", 64'(pend_valid), 64'(pv));
        if (pv) chk("pend_dest", 64'(pend_dest), 64'(pd));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rf_bus", 64'(rf_bus), 64'({e.we, e.addr, e.data}));
            chk("wb_pc", 64'(debug_wb_pc), 64'(e.pc));
            chk("wb_we", 64'(debug_wb_rf_we), 64'({4{e.we}}));
            chk("wb_wnum", 64'(debug_wb_rf_wnum), 64'(e.addr));
        end
        sb.push_back(rec);
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic we, input logic [4:0] d,
                         input logic [31:0] data, input logic [31:0] pc);
        bus.a_valid = v;
        bus.a_we    = we;
        bus.a_dest  = d;
        bus.a_wdata = data;
        bus.a_pc    = pc;
    endtask

    task automatic set_b(input logic v, input logic [4:0] d,
                         input logic [31:0] data, input logic [31:0] pc);
        bus.b_valid = v;
        bus.b_dest  = d;
        bus.b_wdata = data;
        bus.b_pc    = pc;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        last_addr = '0;
        last_data = '0;
        last_pc   = '0;
        reset     = 1'b0;
        set_a(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        set_b(1'b1, 5'd9, 32'h9999, 32'h90);
        @(posedge clk);
        #1;

        // reset held with b_valid high
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 5'd0, rst());

        reset = 1'b1;
        set_b(1'b0, 5'd0, 32'd0, 32'd0);
        tick(1, 1, 0, 5'd0, idle());

        // idle drain
        set_b(1'b1, 5'd5, 32'h1234, 32'h100);
        tick(1, 1, 0, 5'd0, idle());
        set_b(1'b0, 5'd0, 32'd0, 32'd0);
        tick(0, 0, 1, 5'd5, w(1, 5'd5, 32'h1234, 32'h100));
        tick(1, 1, 0, 5'd0, idle());

        // write-after-write: buffered B goes first
        set_b(1'b1, 5'd7, 32'hBBBB, 32'h200);
        tick(1, 1, 0, 5'd0, idle());
        set_b(1'b0, 5'd0, 32'd0, 32'd0);
        set_a(1'b1, 1'b1, 5'd7, 32'hAAAA, 32'h204);
        tick(0, 0, 1, 5'd7, w(1, 5'd7, 32'hBBBB, 32'h200));
        tick(1, 1, 0, 5'd0, w(1, 5'd7, 32'hAAAA, 32'h204));
        set_a(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        tick(1, 1, 0, 5'd0, idle());

        // simultaneous A retire and B accept, then A streams r3
        set_b(1'b1, 5'd10, 32'hC0DE, 32'h300);
        set_a(1'b1, 1'b1, 5'd3, 32'h33, 32'h304);
        tick(1, 1, 0, 5'd0, w(1, 5'd3, 32'h33, 32'h304));
        set_b(1'b0, 5'd0, 32'd0, 32'd0);
`ifdef RF_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) begin
            set_a(1, 1, 5'd3, 32'h40 + 32'(i), 32'h308 + 32'(4 * i));
            tick(1, 0, 1, 5'd10,
                 w(1, 5'd3, 32'h40 + 32'(i), 32'h308 + 32'(4 * i)));
        end
        set_a(1'b1, 1'b1, 5'd3, 32'h44, 32'h318);
        tick(0, 0, 1, 5'd10, w(1, 5'd10, 32'hC0DE, 32'h300));
        tick(1, 1, 0, 5'd0, w(1, 5'd3, 32'h44, 32'h318));
        set_a(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        tick(1, 1, 0, 5'd0, idle());
`else
        for (int i = 0; i < 6; i++) begin
            set_a(1, 1, 5'd3, 32'h40 + 32'(i), 32'h308 + 32'(4 * i));
            tick(1, 0, 1, 5'd10,
                 w(1, 5'd3, 32'h40 + 32'(i), 32'h308 + 32'(4 * i)));
        end
        set_a(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        tick(0, 0, 1, 5'd10, w(1, 5'd10, 32'hC0DE, 32'h300));
        tick(1, 1, 0, 5'd0, idle());
`endif

        // r0 and a_we=0 retirements still produce a record
        set_a(1'b1, 1'b1, 5'd0, 32'hDEAD, 32'h400);
        tick(1, 1, 0, 5'd0, w(0, 5'd0, 32'hDEAD, 32'h400));
        set_a(1'b1, 1'b0, 5'd4, 32'h55, 32'h404);
        tick(1, 1, 0, 5'd0, w(0, 5'd4, 32'h55, 32'h404));
        set_a(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        tick(1, 1, 0, 5'd0, idle());

        // B to r0: no waw with A r0, drains with we=0
        set_b(1'b1, 5'd0, 32'h0B0B, 32'h480);
        tick(1, 1, 0, 5'd0, idle());
        set_b(1'b0, 5'd0, 32'd0, 32'd0);
        set_a(1'b1, 1'b1, 5'd0, 32'h0A0A, 32'h484);
        tick(1, 0, 1, 5'd0, w(0, 5'd0, 32'h0A0A, 32'h484));
        set_a(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        tick(0, 0, 1, 5'd0, w(0, 5'd0, 32'h0B0B, 32'h480));
        tick(1, 1, 0, 5'd0, idle());

        // back-to-back B: one result every two cycles
        set_b(1'b1, 5'd20, 32'h2020, 32'h600);
        tick(1, 1, 0, 5'd0, idle());
        set_b(1'b1, 5'd21, 32'h2121, 32'h604);
        tick(0, 0, 1, 5'd20, w(1, 5'd20, 32'h2020, 32'h600));
        tick(1, 1, 0, 5'd0, idle());
        set_b(1'b0, 5'd0, 32'd0, 32'd0);
        tick(0, 0, 1, 5'd21, w(1, 5'd21, 32'h2121, 32'h604));
        tick(1, 1, 0, 5'd0, idle());

        // reset mid-operation drops the buffered entry
        set_b(1'b1, 5'd12, 32'hFEED, 32'h500);
        tick(1, 1, 0, 5'd0, idle());
        set_b(1'b0, 5'd0, 32'd0, 32'd0);
        reset = 1'b0;
        tick(0, 0, 1, 5'd12, rst());
        reset = 1'b1;
        tick(1, 1, 0, 5'd0, idle());
        tick(1, 1, 0, 5'd0, idle());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
